// File: rtl/em_pipe_reg.sv
// E/M pipeline register for the P7 MIPS core: latches E-stage results, merges ALU overflow into ExcCode.
// Optional build macro EM_PERF_CNT_EN adds retire/bubble performance counters.
module em_pipe_reg #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [4:0]  EXC_OV     = 5'd12,
    parameter logic [4:0]  EXC_ADEL   = 5'd4,
    parameter logic [4:0]  EXC_ADES   = 5'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] E_pc,
    input  logic [31:0] E_instr,
    input  logic [31:0] E_alu_out,
    input  logic [31:0] E_rt_data,
    input  logic        E_bd,
    input  logic [4:0]  E_exc_in,
    input  logic [1:0]  E_cal_op,
    input  logic        E_ari_ov,
    input  logic        E_dm_ov,
    output logic [31:0] M_pc,
    output logic [31:0] M_instr,
    output logic [31:0] M_alu_out,
    output logic [31:0] M_rt_data,
    output logic        M_bd,
    output logic [4:0]  M_exc_code,
    output logic        M_valid
`ifdef EM_PERF_CNT_EN
    ,
    output logic [31:0] perf_retire,
    output logic [31:0] perf_bubble
`endif
);

    localparam logic [1:0] OP_ARITH = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rt_q, rt_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_q, exc_d;
    logic        valid_q, valid_d;
    logic [4:0]  excMerged;
    logic        doLoad;
    logic        doBubble;

    // An exception raised earlier in the pipe outranks anything the ALU reports.
    always_comb begin
        excMerged = 5'd0;
        if (E_exc_in != 5'd0) begin
            excMerged = E_exc_in;
        end else if (E_cal_op == OP_ARITH && E_ari_ov) begin
            excMerged = EXC_OV;
        end else if (E_cal_op == OP_LOAD && E_dm_ov) begin
            excMerged = EXC_ADEL;
        end else if (E_cal_op == OP_STORE && E_dm_ov) begin
            excMerged = EXC_ADES;
        end
    end

    assign doLoad   = !req && !stall && !flush;
    assign doBubble = req || (!stall && flush);

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        alu_d   = alu_q;
        rt_d    = rt_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        valid_d = valid_q;
        if (req) begin
            pc_d    = HANDLER_PC;
            instr_d = 32'd0;
            alu_d   = 32'd0;
            rt_d    = 32'd0;
            bd_d    = 1'b0;
            exc_d   = 5'd0;
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (flush) begin
            // PC and BD survive the bubble so an interrupt taken here still reports a correct EPC.
            pc_d    = E_pc;
            instr_d = 32'd0;
            alu_d   = 32'd0;
            rt_d    = 32'd0;
            bd_d    = E_bd;
            exc_d   = 5'd0;
            valid_d = 1'b0;
        end else begin
            pc_d    = E_pc;
            instr_d = E_instr;
            alu_d   = E_alu_out;
            rt_d    = E_rt_data;
            bd_d    = E_bd;
            exc_d   = excMerged;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
            alu_q   <= 32'd0;
            rt_q    <= 32'd0;
            bd_q    <= 1'b0;
            exc_q   <= 5'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            alu_q   <= alu_d;
            rt_q    <= rt_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            valid_q <= valid_d;
        end
    end

    assign M_pc       = pc_q;
    assign M_instr    = instr_q;
    assign M_alu_out  = alu_q;
    assign M_rt_data  = rt_q;
    assign M_bd       = bd_q;
    assign M_exc_code = exc_q;
    assign M_valid    = valid_q;

`ifdef EM_PERF_CNT_EN
    logic [31:0] retire_q, retire_d;
    logic [31:0] bubble_q, bubble_d;

    // Counters wrap naturally at 32 bits and freeze while the stage is stalled.
    always_comb begin
        retire_d = retire_q;
        bubble_d = bubble_q;
        if (doLoad) begin
            retire_d = retire_q + 32'd1;
        end
        if (doBubble) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= 32'd0;
            bubble_q <= 32'd0;
        end else begin
            retire_q <= retire_d;
            bubble_q <= bubble_d;
        end
    end

    assign perf_retire = retire_q;
    assign perf_bubble = bubble_q;
`else
    logic unusedPerf;
    assign unusedPerf = doLoad ^ doBubble;
`endif

endmodule

// File: tb/tb_em_pipe_reg.sv
// Directed self-checking bench for em_pipe_reg using an expected-state queue.
// Also compares the perf counters when built with EM_PERF_CNT_EN.
module tb_em_pipe_reg;

    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    logic        clk;
    logic        reset;
    logic        req;
    logic        stall;
    logic        flush;
    logic [31:0] E_pc;
    logic [31:0] E_instr;
    logic [31:0] E_alu_out;
    logic [31:0] E_rt_data;
    logic        E_bd;
    logic [4:0]  E_exc_in;
    logic [1:0]  E_cal_op;
    logic        E_ari_ov;
    logic        E_dm_ov;
    logic [31:0] M_pc;
    logic [31:0] M_instr;
    logic [31:0] M_alu_out;
    logic [31:0] M_rt_data;
    logic        M_bd;
    logic [4:0]  M_exc_code;
    logic        M_valid;
`ifdef EM_PERF_CNT_EN
    logic [31:0] perf_retire;
    logic [31:0] perf_bubble;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu;
        logic [31:0] rt;
        logic        bd;
        logic [4:0]  exc;
        logic        valid;
        logic [31:0] retire;
        logic [31:0] bubble;
    } mState_t;

    mState_t expQ[$];
    mState_t model;
    int      checks = 0;
    int      errors = 0;

    em_pipe_reg dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .stall      (stall),
        .flush      (flush),
        .E_pc       (E_pc),
        .E_instr    (E_instr),
        .E_alu_out  (E_alu_out),
        .E_rt_data  (E_rt_data),
        .E_bd       (E_bd),
        .E_exc_in   (E_exc_in),
        .E_cal_op   (E_cal_op),
        .E_ari_ov   (E_ari_ov),
        .E_dm_ov    (E_dm_ov),
        .M_pc       (M_pc),
        .M_instr    (M_instr),
        .M_alu_out  (M_alu_out),
        .M_rt_data  (M_rt_data),
        .M_bd       (M_bd),
        .M_exc_code (M_exc_code),
        .M_valid    (M_valid)
`ifdef EM_PERF_CNT_EN
        ,
        .perf_retire(perf_retire),
        .perf_bubble(perf_bubble)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string step);
        mState_t e;
        if (expQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s scoreboard empty observed=0 expected=1", step);
            return;
        end
        e = expQ.pop_front();
        checkField({step, ".M_pc"},       M_pc,       e.pc);
        checkField({step, ".M_instr"},    M_instr,    e.instr);
        checkField({step, ".M_alu_out"},  M_alu_out,  e.alu);
        checkField({step, ".M_rt_data"},  M_rt_data,  e.rt);
        checkField({step, ".M_bd"},       {31'd0, M_bd},       {31'd0, e.bd});
        checkField({step, ".M_exc_code"}, {27'd0, M_exc_code}, {27'd0, e.exc});
        checkField({step, ".M_valid"},    {31'd0, M_valid},    {31'd0, e.valid});
`ifdef EM_PERF_CNT_EN
        checkField({step, ".perf_retire"}, perf_retire, e.retire);
        checkField({step, ".perf_bubble"}, perf_bubble, e.bubble);
`endif
    endtask

    task automatic resetModel();
        model = '{pc: 32'd0, instr: 32'd0, alu: 32'd0, rt: 32'd0, bd: 1'b0,
                  exc: 5'd0, valid: 1'b0, retire: 32'd0, bubble: 32'd0};
    endtask

    // Drive one cycle of E inputs, predict the M register contents, then check after the edge.
    task automatic applyStimulus(input string step, input logic r, input logic s, input logic f,
                                 input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [31:0] alu, input logic [31:0] rt, input logic bd,
                                 input logic [4:0] excIn, input logic [1:0] op,
                                 input logic ari, input logic dm, input logic [4:0] expExc);
        req = r; stall = s; flush = f;
        E_pc = pc; E_instr = instr; E_alu_out = alu; E_rt_data = rt; E_bd = bd;
        E_exc_in = excIn; E_cal_op = op; E_ari_ov = ari; E_dm_ov = dm;
        if (r) begin
            model.pc = HANDLER_PC; model.instr = 0; model.alu = 0; model.rt = 0;
            model.bd = 0; model.exc = 0; model.valid = 0;
            model.bubble = model.bubble + 1;
        end else if (!s && f) begin
            model.pc = pc; model.instr = 0; model.alu = 0; model.rt = 0;
            model.bd = bd; model.exc = 0; model.valid = 0;
            model.bubble = model.bubble + 1;
        end else if (!s) begin
            model.pc = pc; model.instr = instr; model.alu = alu; model.rt = rt;
            model.bd = bd; model.exc = expExc; model.valid = 1;
            model.retire = model.retire + 1;
        end
        expQ.push_back(model);
        @(posedge clk);
        #1;
        checkOutput(step);
    endtask

    initial begin
        reset = 1'b1;
        req = 0; stall = 0; flush = 0;
        E_pc = 0; E_instr = 0; E_alu_out = 0; E_rt_data = 0; E_bd = 0;
        E_exc_in = 0; E_cal_op = 0; E_ari_ov = 0; E_dm_ov = 0;
        #2;
        resetModel();
        expQ.push_back(model);
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("load0",     0, 0, 0, 32'h3000, 32'h8C01_0004, 32'h1234, 32'hAAAA_5555, 0, 5'd0,  2'b00, 0, 0, 5'd0);
        applyStimulus("ovArith",   0, 0, 0, 32'h3004, 32'h0022_0820, 32'h7FFF_FFFF, 32'h1, 0, 5'd0, 2'b01, 1, 0, 5'd12);
        applyStimulus("excInWins", 0, 0, 0, 32'h3008, 32'h0022_0820, 32'h8000_0000, 32'h2, 1, 5'd10, 2'b01, 1, 0, 5'd10);
        applyStimulus("adel",      0, 0, 0, 32'h300C, 32'h8C22_0000, 32'hFFFF_FFFC, 32'h3, 0, 5'd0, 2'b10, 0, 1, 5'd4);
        applyStimulus("ades",      0, 0, 0, 32'h3010, 32'hAC22_0000, 32'hFFFF_FFF8, 32'h4, 0, 5'd0, 2'b11, 0, 1, 5'd5);
        applyStimulus("dmOpOther", 0, 0, 0, 32'h3014, 32'h0000_0000, 32'h5, 32'h5, 0, 5'd0, 2'b00, 0, 1, 5'd0);
        applyStimulus("ariOnLoad", 0, 0, 0, 32'h3018, 32'h8C22_0010, 32'h6, 32'h6, 0, 5'd0, 2'b10, 1, 0, 5'd0);
        applyStimulus("dmOnArith", 0, 0, 0, 32'h301C, 32'h0022_0820, 32'h7, 32'h7, 0, 5'd0, 2'b01, 0, 1, 5'd0);

        applyStimulus("preStall",  0, 0, 0, 32'h3020, 32'h1234_5678, 32'hCAFE_0000, 32'hBEEF, 1, 5'd0, 2'b01, 1, 0, 5'd12);
        applyStimulus("stall1",    0, 1, 0, 32'h5000, 32'h1111_1111, 32'h2222, 32'h3333, 0, 5'd3, 2'b00, 0, 0, 5'd0);
        applyStimulus("stall2",    0, 1, 1, 32'h5004, 32'h4444_4444, 32'h5555, 32'h6666, 0, 5'd0, 2'b11, 0, 1, 5'd0);
        applyStimulus("stall3",    0, 1, 0, 32'h5008, 32'h7777_7777, 32'h8888, 32'h9999, 1, 5'd0, 2'b10, 0, 1, 5'd0);
        applyStimulus("flush",     0, 0, 1, 32'h3010, 32'hDEAD_BEEF, 32'h1234, 32'h5678, 1, 5'd7, 2'b01, 1, 1, 5'd0);

        applyStimulus("load1",     0, 0, 0, 32'h3030, 32'h0123_4567, 32'h89AB, 32'hCDEF, 1, 5'd0, 2'b11, 0, 1, 5'd5);
        applyStimulus("reqStall",  1, 1, 0, 32'h3034, 32'hFFFF_FFFF, 32'hFFFF, 32'hFFFF, 1, 5'd8, 2'b01, 1, 1, 5'd0);
        applyStimulus("load2",     0, 0, 0, 32'h4180, 32'h2402_000A, 32'hA, 32'hB, 0, 5'd0, 2'b00, 0, 0, 5'd0);
        applyStimulus("reqFlush",  1, 0, 1, 32'h4184, 32'h2402_000B, 32'hC, 32'hD, 1, 5'd0, 2'b00, 0, 0, 5'd0);
        applyStimulus("load3",     0, 0, 0, 32'h4188, 32'h2402_000C, 32'hE, 32'hF, 1, 5'd0, 2'b00, 0, 0, 5'd0);

        #3;
        reset = 1'b1;
        #1;
        resetModel();
        expQ.push_back(model);
        checkOutput("asyncReset");
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("stallZero", 0, 1, 0, 32'h6000, 32'h6666_6666, 32'h66, 32'h77, 1, 5'd9, 2'b01, 1, 1, 5'd0);
        applyStimulus("load4",     0, 0, 0, 32'h6004, 32'h0000_0020, 32'h99, 32'h88, 0, 5'd0, 2'b01, 1, 0, 5'd12);
        applyStimulus("flush2",    0, 0, 1, 32'h6008, 32'h0000_0021, 32'h98, 32'h87, 0, 5'd0, 2'b00, 0, 0, 5'd0);
        applyStimulus("load5",     0, 0, 0, 32'h600C, 32'h0000_0022, 32'h97, 32'h86, 0, 5'd0, 2'b00, 0, 0, 5'd0);

        if (expQ.size() != 0) begin
            errors++;
            $error("[TB] FAIL scoreboardDrain observed=%0d expected=0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
